// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID/EX stall, flush and bubble sequencing around the execute stage
// Optional multi-cycle watchdog: define HAZARD_MC_TIMEOUT_EN to add the wait counter and mc_error.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_mc_op,
  input  logic        ex_valid,
  input  logic [2:0]  ex_info_load,
  input  logic        ex_write_reg,
  input  logic [4:0]  ex_dstreg_addr,
  input  logic        ex_redirect,
  input  logic        mc_done,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic        mc_start,
  output logic        busy,
  output logic [31:0] lost_cycles
`ifdef HAZARD_MC_TIMEOUT_EN
  ,
  output logic        mc_error
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_MC_WAIT
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] lost_q;
  logic        load_use;
  logic        mc_timeout;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = ex_valid && (ex_info_load != 3'd0) && ex_write_reg &&
                    (ex_dstreg_addr != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_dstreg_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_dstreg_addr)));

`ifdef HAZARD_MC_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mc_error_q;

  assign mc_timeout = (state_q == S_MC_WAIT) && !mc_done &&
                      (wait_cnt_q == 8'(MC_TIMEOUT - 1));

  // Held at zero outside MC_WAIT so every entry starts a fresh count
  always_comb begin
    wait_cnt_d = 8'd0;
    if (state_q == S_MC_WAIT && !mc_done) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      mc_error_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (mc_timeout) begin
        mc_error_q <= 1'b1;
      end
    end
  end

  assign mc_error = mc_error_q;
`else
  logic unused_mc_timeout;
  assign unused_mc_timeout = (MC_TIMEOUT > 0);
  assign mc_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= 3'd0;
      lost_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if ((stall_if || flush_id) && (lost_q != 32'hFFFF_FFFF)) begin
        lost_q <= lost_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_RUN: begin
        if (ex_redirect) begin
          flush_cnt_d = FLUSH_INIT;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
          end
        end else if (id_valid && id_mc_op) begin
          state_d = S_MC_WAIT;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d = S_RUN;
        end
      end
      S_MC_WAIT: begin
        if (mc_done || mc_timeout) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    mc_start  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_q != S_RUN);
      case (state_q)
        S_RUN: begin
          if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (id_valid && id_mc_op) begin
            mc_start = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        S_FLUSH: begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end
        S_MC_WAIT: begin
          // Release in the completion cycle so the waiting instruction enters EX with the result
          if (!(mc_done || mc_timeout)) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lost_cycles = lost_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_mc_op;
  logic        ex_valid;
  logic [2:0]  ex_info_load;
  logic        ex_write_reg;
  logic [4:0]  ex_dstreg_addr;
  logic        ex_redirect;
  logic        mc_done;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        bubble_ex;
  logic        mc_start;
  logic        busy;
  logic [31:0] lost_cycles;
`ifdef HAZARD_MC_TIMEOUT_EN
  logic        mc_error;
`endif

  // {stall_if, stall_id, flush_id, bubble_ex, mc_start, busy}
  localparam logic [5:0] E_IDLE   = 6'b000000;
  localparam logic [5:0] E_LU     = 6'b110100;
  localparam logic [5:0] E_REDIR  = 6'b001100;
  localparam logic [5:0] E_FLUSH  = 6'b001101;
  localparam logic [5:0] E_MCST   = 6'b110010;
  localparam logic [5:0] E_MCWAIT = 6'b110101;
  localparam logic [5:0] E_MCDONE = 6'b000001;

  logic [5:0]  ctrl;
  logic [5:0]  sb_q[$];
  logic [5:0]  exp_v;
  logic [31:0] lost_m;
  int          n_cmp;
  int          n_err;

  assign ctrl = {stall_if, stall_id, flush_id, bubble_ex, mc_start, busy};

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MC_TIMEOUT  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_mc_op      (id_mc_op),
    .ex_valid      (ex_valid),
    .ex_info_load  (ex_info_load),
    .ex_write_reg  (ex_write_reg),
    .ex_dstreg_addr(ex_dstreg_addr),
    .ex_redirect   (ex_redirect),
    .mc_done       (mc_done),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush_id      (flush_id),
    .bubble_ex     (bubble_ex),
    .mc_start      (mc_start),
    .busy          (busy),
    .lost_cycles   (lost_cycles)
`ifdef HAZARD_MC_TIMEOUT_EN
    ,
    .mc_error      (mc_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    id_valid       = 1'b0;
    id_rs1_addr    = 5'd0;
    id_rs2_addr    = 5'd0;
    id_uses_rs1    = 1'b0;
    id_uses_rs2    = 1'b0;
    id_mc_op       = 1'b0;
    ex_valid       = 1'b0;
    ex_info_load   = 3'd0;
    ex_write_reg   = 1'b0;
    ex_dstreg_addr = 5'd0;
    ex_redirect    = 1'b0;
    mc_done        = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] dst, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    ex_valid       = 1'b1;
    ex_info_load   = 3'b010;
    ex_write_reg   = 1'b1;
    ex_dstreg_addr = dst;
    id_valid       = 1'b1;
    id_rs1_addr    = rs1;
    id_rs2_addr    = rs2;
    id_uses_rs1    = u1;
    id_uses_rs2    = u2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; clear_in();
      rst = 1'b1; ex_redirect = 1'b1; id_valid = 1'b1; id_mc_op = 1'b1;
      sb_q.push_back(E_IDLE);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL reset[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (lost_cycles !== 32'd0) begin n_err++; $display("FAIL reset[%0d] lost got %0d want 0", i, lost_cycles); end
    end
    lost_m = 32'd0;
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; clear_in(); rst = 1'b0;
      case (i)
        0: begin set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); sb_q.push_back(E_LU); end
        2: begin set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); sb_q.push_back(E_IDLE); end
        3: begin set_load(5'd9, 5'd1, 5'd9, 1'b1, 1'b1); sb_q.push_back(E_LU); end
        4: begin set_load(5'd9, 5'd9, 5'd1, 1'b0, 1'b1); sb_q.push_back(E_IDLE); end
        5: begin set_load(5'd7, 5'd7, 5'd7, 1'b1, 1'b1); ex_write_reg = 1'b0; sb_q.push_back(E_IDLE); end
        6: begin set_load(5'd7, 5'd7, 5'd0, 1'b1, 1'b0); id_valid = 1'b0; sb_q.push_back(E_IDLE); end
        7: begin set_load(5'd7, 5'd7, 5'd0, 1'b1, 1'b0); ex_info_load = 3'd0; sb_q.push_back(E_IDLE); end
        default: sb_q.push_back(E_IDLE);
      endcase
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL load_use[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (lost_cycles !== lost_m) begin n_err++; $display("FAIL load_use[%0d] lost got %0d want %0d", i, lost_cycles, lost_m); end
      lost_m = lost_m + {31'd0, exp_v[5] | exp_v[3]};
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; clear_in(); rst = 1'b0;
      case (i)
        0: begin ex_redirect = 1'b1; sb_q.push_back(E_REDIR); end
        1: begin ex_redirect = 1'b1; sb_q.push_back(E_FLUSH); end
        3: begin ex_redirect = 1'b1; set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
                 id_mc_op = 1'b1; sb_q.push_back(E_REDIR); end
        4: begin set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); sb_q.push_back(E_FLUSH); end
        default: sb_q.push_back(E_IDLE);
      endcase
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL redirect[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (lost_cycles !== lost_m) begin n_err++; $display("FAIL redirect[%0d] lost got %0d want %0d", i, lost_cycles, lost_m); end
      lost_m = lost_m + {31'd0, exp_v[5] | exp_v[3]};
    end
  endtask

  task automatic test_multicycle();
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1; clear_in(); rst = 1'b0;
      case (i)
        0: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCST); end
        1, 2, 3, 4: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCWAIT); end
        5: begin id_valid = 1'b1; id_mc_op = 1'b1; mc_done = 1'b1; sb_q.push_back(E_MCDONE); end
        7: begin mc_done = 1'b1; sb_q.push_back(E_IDLE); end
        8: begin mc_done = 1'b1; ex_redirect = 1'b1; sb_q.push_back(E_REDIR); end
        9: begin mc_done = 1'b1; sb_q.push_back(E_FLUSH); end
        default: sb_q.push_back(E_IDLE);
      endcase
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL multicycle[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (lost_cycles !== lost_m) begin n_err++; $display("FAIL multicycle[%0d] lost got %0d want %0d", i, lost_cycles, lost_m); end
      lost_m = lost_m + {31'd0, exp_v[5] | exp_v[3]};
    end
  endtask

  task automatic test_reset_mid_mc();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; clear_in(); rst = 1'b0;
      case (i)
        0: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCST); end
        1: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCWAIT); end
        2: begin rst = 1'b1; id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_IDLE); end
        4: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCST); end
        5: begin mc_done = 1'b1; sb_q.push_back(E_MCDONE); end
        default: sb_q.push_back(E_IDLE);
      endcase
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL reset_mid_mc[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (lost_cycles !== lost_m) begin n_err++; $display("FAIL reset_mid_mc[%0d] lost got %0d want %0d", i, lost_cycles, lost_m); end
      lost_m = rst ? 32'd0 : lost_m + {31'd0, exp_v[5] | exp_v[3]};
    end
  endtask

`ifdef HAZARD_MC_TIMEOUT_EN
  task automatic test_timeout();
    logic exp_err;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1; clear_in(); rst = 1'b0;
      case (i)
        0: begin id_valid = 1'b1; id_mc_op = 1'b1; sb_q.push_back(E_MCST); end
        1, 2, 3, 4, 5, 6, 7: sb_q.push_back(E_MCWAIT);
        8: sb_q.push_back(E_MCDONE);
        10: begin mc_done = 1'b1; sb_q.push_back(E_IDLE); end
        11: begin rst = 1'b1; sb_q.push_back(E_IDLE); end
        default: sb_q.push_back(E_IDLE);
      endcase
      exp_err = (i >= 9) && (i <= 11);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (ctrl !== exp_v) begin n_err++; $display("FAIL timeout[%0d] ctrl got %b want %b", i, ctrl, exp_v); end
      n_cmp++;
      if (mc_error !== exp_err) begin n_err++; $display("FAIL timeout[%0d] mc_error got %b want %b", i, mc_error, exp_err); end
      n_cmp++;
      if (lost_cycles !== lost_m) begin n_err++; $display("FAIL timeout[%0d] lost got %0d want %0d", i, lost_cycles, lost_m); end
      lost_m = rst ? 32'd0 : lost_m + {31'd0, exp_v[5] | exp_v[3]};
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    lost_m = 32'd0;
    rst    = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_redirect();
    test_multicycle();
    test_reset_mid_mc();
`ifdef HAZARD_MC_TIMEOUT_EN
    test_timeout();
`endif
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage core around the execute stage by generating stall, flush and bubble controls for IF/ID/EX.
- Detects load-use hazards against the instruction in EX and applies control-transfer redirects from EX.
- Handshakes with the multi-cycle unit (mul/div) that shares the EX slot.
- Counts lost cycles for performance analysis.

Parameters:
- FLUSH_CYCLES, 2: cycles IF/ID are flushed after a redirect (1..7).
- MC_TIMEOUT, 64: watchdog limit in cycles; used only with the optional feature (1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr  in  5  ID source register 1.
- id_rs2_addr  in  5  ID source register 2.
- id_uses_rs1  in  1  ID reads rs1.
- id_uses_rs2  in  1  ID reads rs2.
- id_mc_op  in  1  ID instruction needs the multi-cycle unit.
- ex_valid  in  1  EX holds a real instruction.
- ex_info_load  in  3  EX load code; nonzero means a load.
- ex_write_reg  in  1  EX writes a register.
- ex_dstreg_addr  in  5  EX destination register.
- ex_redirect  in  1  EX resolved a taken branch/JAL/JALR (next_pc != pc+4).
- mc_done  in  1  multi-cycle unit result valid, 1-cycle pulse.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  clear IF/ID register to a bubble.
- bubble_ex  out  1  insert a bubble into ID/EX.
- mc_start  out  1  launch multi-cycle op, 1-cycle pulse.
- busy  out  1  FSM not in RUN.
- lost_cycles  out  32  saturating count of cycles with stall_if or flush_id high.
- mc_error  out  1  sticky watchdog flag; present only with the optional feature.

Behaviour:
- States: RUN, FLUSH, MC_WAIT. Encoding is free.
- All registers update on posedge clk. Outputs are combinational from state and inputs.
- While rst=1: state=RUN, counters=0, mc_error=0, all outputs 0. This applies mid-operation too: an in-flight MC_WAIT is abandoned.
- Signal definitions:
  - load_use = ex_valid & (ex_info_load!=0) & ex_write_reg & (ex_dstreg_addr!=0) & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_dstreg_addr) | (id_uses_rs2 & id_rs2_addr==ex_dstreg_addr)).
  - Register x0 never causes a hazard.
- RUN, priority order, highest first:
  - (a) ex_redirect: flush_id=1, bubble_ex=1, stall_if=0. Go to FLUSH with flush_cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN. Redirect overrides a simultaneous load_use or id_mc_op.
  - (b) id_valid & id_mc_op: mc_start=1, stall_if=1, stall_id=1, bubble_ex=0. Go to MC_WAIT.
  - (c) load_use: stall_if=1, stall_id=1, bubble_ex=1 for exactly that cycle. Next cycle the load has left EX, so load_use clears naturally. No extra state.
  - (d) otherwise all controls 0.
- FLUSH:
  - flush_id=1, bubble_ex=1.
  - flush_cnt decrements each cycle; at 0 return to RUN.
  - A new ex_redirect in FLUSH is ignored, because EX only holds bubbles.
- MC_WAIT:
  - stall_if=1, stall_id=1, bubble_ex=1, mc_start=0.
  - On mc_done: stall_if=0, stall_id=0, bubble_ex=0 that cycle, so ID advances into EX with the result; go to RUN.
  - mc_done in RUN or FLUSH is ignored.
- busy = (state != RUN).
- lost_cycles: increments by 1 whenever stall_if|flush_id is high. Saturates at 0xFFFFFFFF, no wrap.

Optional Feature:
- Macro: HAZARD_MC_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to MC_WAIT and increments each MC_WAIT cycle without mc_done.
  - When the counter reaches MC_TIMEOUT, set mc_error=1 (sticky until rst) and return to RUN, releasing stalls that cycle.
  - A late mc_done afterwards is ignored.
- Undefined: no counter, no mc_error port; MC_WAIT waits indefinitely.

Test Plan:
- Load x5 in EX (ex_info_load=3'b010), ID reads rs1=x5 -> exactly 1 cycle stall_if=stall_id=bubble_ex=1, then all 0, lost_cycles=1. Same with x0 -> no stall.
- ex_redirect=1 in RUN with FLUSH_CYCLES=2 -> flush_id=1 for 2 consecutive cycles, busy=1 on the 2nd only, lost_cycles=2.
- ex_redirect and load_use in the same cycle -> flush_id=1, stall_if=0; no load-use stall follows.
- id_mc_op=1 -> mc_start pulses 1 cycle; stalls held; mc_done after 5 cycles -> stalls drop in the mc_done cycle, state RUN next.
- rst pulsed during MC_WAIT -> next cycle state RUN, all outputs 0, lost_cycles=0.
- With HAZARD_MC_TIMEOUT_EN and MC_TIMEOUT=8, mc_done never arrives -> mc_error=1 after 8 wait cycles, state RUN, stays 1 until rst.
